// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg: state type, parameter defaults and ratio helper for the clock divider
package clock_divider_pkg;
  localparam int unsigned DEF_WIDTH = 36;
  localparam longint unsigned DEF_DIVIDE = 100000000;
  localparam int unsigned DEF_MIN_DIV = 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic logic [DEF_WIDTH-1:0] half(input logic [DEF_WIDTH-1:0] d);
    return d >> 1;
  endfunction
endpackage

// File: rtl/clock_divider_core.sv
// clock_divider_core: period counter, wrap detect and registered clock_out/tick generation
module clock_divider_core
  import clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             en,
  input  logic             en_nxt,
  input  logic [WIDTH-1:0] active,
  input  logic [WIDTH-1:0] active_nxt,
  output logic             wrap,
  output logic             clock_out,
  output logic             tick
);
  localparam logic [WIDTH-1:0] ONE = 1;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  assign wrap = en && cnt == active - ONE;
  // a count at or past the ratio restarts the period instead of running on
  assign cnt_nxt = (en && en_nxt && !wrap && cnt < active) ? cnt + ONE : '0;
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt       <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      clock_out <= en_nxt && cnt_nxt < half(active_nxt);
      tick      <= en_nxt && cnt_nxt == active_nxt - ONE;
    end
  end
endmodule

// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl: run/stop sequencer with glitch-free ratio reload; CLOCK_DIVIDER_CTRL_PCOUNT_EN adds period_count
module clock_divider_ctrl
  import clock_divider_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEF_DIVIDE),
  parameter logic [WIDTH-1:0] MIN_DIV     = WIDTH'(DEF_MIN_DIV)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_divide,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clock_out,
  output logic             tick,
`ifdef CLOCK_DIVIDER_CTRL_PCOUNT_EN
  output logic [31:0]      period_count,
`endif
  output logic             busy
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] active, active_nxt, pend;
  logic pend_v, wrap, go, xfer, bad, take_pend;
  assign go = start && !stop;
  assign busy = state != IDLE;
  assign cfg_ready = !busy || !pend_v;
  assign xfer = cfg_valid && cfg_ready;
  assign bad = cfg_divide < MIN_DIV;
  assign take_pend = busy && xfer && !bad;
  assign state_nxt = state == IDLE ? (go ? RUN : IDLE)
                   : state == RUN  ? (stop ? DRAIN : RUN)
                   : go ? RUN : wrap ? IDLE : DRAIN;
  // ratios only change while idle or exactly at a period boundary
  assign active_nxt = (wrap && pend_v) ? pend
                    : (!busy && xfer && !bad) ? cfg_divide : active;
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state   <= IDLE;
      active  <= DEFAULT_DIV;
      pend    <= '0;
      pend_v  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      active  <= active_nxt;
      cfg_err <= xfer && bad;
      pend_v  <= take_pend ? 1'b1 : wrap ? 1'b0 : pend_v;
      if (take_pend) pend <= cfg_divide;
    end
  end
  clock_divider_core #(.WIDTH(WIDTH)) u_core (
    .clock_in   (clock_in),
    .reset      (reset),
    .en         (busy),
    .en_nxt     (state_nxt != IDLE),
    .active     (active),
    .active_nxt (active_nxt),
    .wrap       (wrap),
    .clock_out  (clock_out),
    .tick       (tick)
  );
`ifdef CLOCK_DIVIDER_CTRL_PCOUNT_EN
  always_ff @(posedge clock_in) begin
    if (reset || (state == IDLE && state_nxt == RUN)) period_count <= '0;
    else if (tick && period_count != '1) period_count <= period_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb_clock_divider_ctrl: scoreboard bench driving directed and random traffic against a period-level model
module tb_clock_divider_ctrl;
  localparam longint unsigned DEF = 7;
  logic clock_in = 1'b0;
  logic reset, start, stop, cfg_valid;
  logic [35:0] cfg_divide;
  logic cfg_ready, cfg_err, clock_out, tick, busy;
  logic [31:0] pc_dut;
  int n_assert = 0;
  int n_fail = 0;
  always #5 clock_in = ~clock_in;
  clock_divider_ctrl #(.DEFAULT_DIV(36'd7)) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .cfg_valid    (cfg_valid),
    .cfg_divide   (cfg_divide),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .clock_out    (clock_out),
    .tick         (tick),
`ifdef CLOCK_DIVIDER_CTRL_PCOUNT_EN
    .period_count (pc_dut),
`endif
    .busy         (busy)
  );
`ifndef CLOCK_DIVIDER_CTRL_PCOUNT_EN
  assign pc_dut = '0;
`endif
  typedef struct packed { logic co; logic tk; } smp_t;
  typedef struct packed { logic co; logic tk; logic busy; logic rdy; logic err; logic [31:0] pc; } exp_t;
  // model: mode 0 idle / 1 run / 2 drain; m_rem holds the rest of the current period's waveform
  int m_mode;
  smp_t m_rem[$];
  longint unsigned m_active, m_pend;
  logic m_pv, m_err;
  logic [31:0] m_pc;
  exp_t exp_q[$];
  exp_t mon_e;
  function automatic void build(longint unsigned d);
    m_rem.delete();
    for (longint unsigned i = 0; i < d / 2; i++) m_rem.push_back(2'b10);
    for (longint unsigned i = d / 2; i < d; i++) m_rem.push_back(i == d - 1 ? 2'b01 : 2'b00);
  endfunction
  function automatic void m_step(logic r, logic s, logic p, logic v, longint unsigned d);
    logic xfer, bad, last;
    if (r) begin
      m_mode = 0; m_rem.delete(); m_active = DEF; m_pv = 0; m_err = 0; m_pc = 0;
      return;
    end
    xfer = v && (m_mode == 0 || !m_pv);
    bad = d < 2;
    m_err = xfer && bad;
    if (m_mode == 0) begin
      if (xfer && !bad) m_active = d;
      if (s && !p) begin m_mode = 1; build(m_active); m_pc = 0; end
      return;
    end
    if (m_rem[0].tk && m_pc != 32'hFFFF_FFFF) m_pc++;
    last = m_rem.size() == 1;
    void'(m_rem.pop_front());
    if (last && m_pv) begin m_active = m_pend; m_pv = 0; end
    if (xfer && !bad) begin m_pend = d; m_pv = 1; end
    if (m_mode == 1 && p) m_mode = 2;
    else if (m_mode == 2 && s && !p) m_mode = 1;
    else if (m_mode == 2 && last) m_mode = 0;
    if (m_mode != 0 && last) build(m_active);
    if (m_mode == 0) m_rem.delete();
  endfunction
  function automatic exp_t m_out();
    exp_t e;
    e.co = m_mode != 0 && m_rem[0].co;
    e.tk = m_mode != 0 && m_rem[0].tk;
    e.busy = m_mode != 0;
    e.rdy = m_mode == 0 || !m_pv;
    e.err = m_err;
`ifdef CLOCK_DIVIDER_CTRL_PCOUNT_EN
    e.pc = m_pc;
`else
    e.pc = '0;
`endif
    return e;
  endfunction
  function automatic void chk(string nm, longint unsigned act, longint unsigned req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endfunction
  task automatic drive(logic r, logic s, logic p, logic v, longint unsigned d);
    @(negedge clock_in);
    reset = r; start = s; stop = p; cfg_valid = v; cfg_divide = d[35:0];
    @(posedge clock_in);
    m_step(r, s, p, v, d);
    exp_q.push_back(m_out());
  endtask
  always @(negedge clock_in) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("clock_out", clock_out, mon_e.co);
      chk("tick", tick, mon_e.tk);
      chk("busy", busy, mon_e.busy);
      chk("cfg_ready", cfg_ready, mon_e.rdy);
      chk("cfg_err", cfg_err, mon_e.err);
`ifdef CLOCK_DIVIDER_CTRL_PCOUNT_EN
      chk("period_count", pc_dut, mon_e.pc);
`endif
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    logic r, s, p, v;
    longint unsigned d;
    reset = 1; start = 0; stop = 0; cfg_valid = 0; cfg_divide = '0;
    m_mode = 0; m_active = DEF; m_pend = 0; m_pv = 0; m_err = 0; m_pc = 0;
    repeat (2) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 4);
    repeat (12) drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 6);
    repeat (14) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5);
    repeat (9) drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    repeat (10) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    repeat (8) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 3);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (10) drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 299) == 0;
      s = $urandom_range(0, 3) == 0;
      p = $urandom_range(0, 11) == 0;
      v = $urandom_range(0, 2) == 0;
      d = $urandom_range(0, 12);
      drive(r, s, p, v, d);
    end
    drive(0, 0, 1, 0, 0);
    repeat (15) drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clock_in);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
